bme_preimage_search: RTL

BME_PREIMAGE_SEARCH -- requirements
Module: bme_preimage_search

---
 rtl/bme_preimage_search_if.sv | 19 +
 rtl/bme_preimage_search.sv | 83 ++++++++
 2 files changed

// File: rtl/bme_preimage_search_if.sv
// bme_preimage_search_if: search request/target and result bus for bme_preimage_search
interface bme_preimage_search_if;
  logic        start_i;
  logic        w_i, x_i, y_i, z_i;
  logic        busy_o;
  logic        done_o;
  logic        found_o;
  logic [15:0] match_mask_o;
  logic [4:0]  match_count_o;
  logic [3:0]  first_match_o;
  modport master (
    output start_i, w_i, x_i, y_i, z_i,
    input  busy_o, done_o, found_o, match_mask_o, match_count_o, first_match_o
  );
  modport slave (
    input  start_i, w_i, x_i, y_i, z_i,
    output busy_o, done_o, found_o, match_mask_o, match_count_o, first_match_o
  );
endinterface

// File: rtl/bme_preimage_search.sv
// bme_preimage_search: sequentially tests all 16 {a,b,c,d} inputs of a BME gate against an observed output
module bme_preimage_search (
  input logic                   clk,
  input logic                   rst,
  bme_preimage_search_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, tgt_q, tgt_d, first_q, first_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        found_q, found_d, done_q, done_d;
  logic [3:0]  fwd;
  logic        hit;
  // forward map of the candidate under evaluation: {w',x',y',z'}
  assign fwd = {idx_q[3],
                (idx_q[3] & idx_q[2]) ^ idx_q[1],
                (idx_q[3] & idx_q[0]) ^ idx_q[1],
                (~idx_q[3] & idx_q[2]) ^ idx_q[1] ^ idx_q[0]};
  assign hit = fwd == tgt_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    found_d = found_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start_i) begin
        state_d = SEARCH;
        tgt_d   = {bus.w_i, bus.x_i, bus.y_i, bus.z_i};
        idx_d   = 4'd0;
        mask_d  = 16'd0;
        cnt_d   = 5'd0;
        first_d = 4'd0;
        found_d = 1'b0;
      end
      SEARCH: begin
        idx_d = idx_q + 4'd1;
        if (hit) begin
          mask_d[idx_q] = 1'b1;
          cnt_d         = cnt_q + 5'd1;
          first_d       = found_q ? first_q : idx_q;
          found_d       = 1'b1;
        end
        if (idx_q == 4'd15) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      tgt_q   <= 4'd0;
      mask_q  <= 16'd0;
      cnt_q   <= 5'd0;
      first_q <= 4'd0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      found_q <= found_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy_o        = state_q == SEARCH;
  assign bus.done_o        = done_q;
  assign bus.found_o       = found_q;
  assign bus.match_mask_o  = mask_q;
  assign bus.match_count_o = cnt_q;
  assign bus.first_match_o = first_q;
endmodule
